// File: rtl/lighting_scene_controller.sv
// Cabin lighting scene arbiter: picks emer > crew > auto and ramps light_level toward the target.
// Latency: ack one edge after req; STEP_CYCLES edges per brightness step.
// Backpressure: requests stay pending while RAMP runs (only emer preempts); en=0 freezes everything.
module lighting_scene_controller #(
    parameter int STEP_CYCLES = 5,
    parameter int STEP_SIZE   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       emer_req,
    input  logic       crew_req,
    input  logic       auto_req,
    input  logic [7:0] emer_target,
    input  logic [7:0] crew_target,
    input  logic [7:0] auto_target,
    output logic [2:0] ack,
    output logic [7:0] light_level,
    output logic [1:0] active_src,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [3:0] LAST_TICK = 4'(STEP_CYCLES - 1);
    localparam logic [7:0] STEP      = 8'(STEP_SIZE);

    state_t     state;
    logic [3:0] timer;
    logic [7:0] target;

    logic       req_vld;
    logic [1:0] req_src;
    logic [7:0] req_dat;
    logic [2:0] req_ack;
    logic       going_up;
    logic [7:0] diff;
    logic [7:0] step_amt;
    logic [7:0] next_level;

    always_comb begin
        req_vld = emer_req | crew_req | auto_req;
        req_src = 2'd0;
        req_dat = 8'd0;
        req_ack = 3'b000;
        if (emer_req) begin
            req_src = 2'd3;
            req_dat = emer_target;
            req_ack = 3'b100;
        end else if (crew_req) begin
            req_src = 2'd2;
            req_dat = crew_target;
            req_ack = 3'b010;
        end else if (auto_req) begin
            req_src = 2'd1;
            req_dat = auto_target;
            req_ack = 3'b001;
        end

        // Clamp the step to the remaining distance so the level can neither wrap nor overshoot.
        going_up   = (target >= light_level);
        diff       = going_up ? (target - light_level) : (light_level - target);
        step_amt   = (diff < STEP) ? diff : STEP;
        next_level = going_up ? (light_level + step_amt) : (light_level - step_amt);
    end

    assign busy = (state == RAMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= 4'd0;
            target      <= 8'd0;
            light_level <= 8'd0;
            active_src  <= 2'd0;
            ack         <= 3'b000;
            done        <= 1'b0;
        end else begin
            ack  <= 3'b000;
            done <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        if (req_vld) begin
                            ack    <= req_ack;
                            target <= req_dat;
                            timer  <= 4'd0;
                            if (req_dat == light_level) begin
                                done       <= 1'b1;
                                active_src <= 2'd0;
                            end else begin
                                active_src <= req_src;
                                state      <= RAMP;
                            end
                        end
                    end
                    RAMP: begin
                        if (emer_req && active_src != 2'd3) begin
                            // Preemption keeps the current level and restarts the step interval.
                            ack        <= 3'b100;
                            target     <= emer_target;
                            active_src <= 2'd3;
                            timer      <= 4'd0;
                        end else if (timer == LAST_TICK) begin
                            timer       <= 4'd0;
                            light_level <= next_level;
                            if (next_level == target) begin
                                done       <= 1'b1;
                                active_src <= 2'd0;
                                state      <= IDLE;
                            end
                        end else begin
                            timer <= timer + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lighting_scene_controller.sv
// Directed bench for lighting_scene_controller with STEP_CYCLES=5, STEP_SIZE=16.
module tb_lighting_scene_controller;

    logic       clk;
    logic       reset;
    logic       en;
    logic       emer_req, crew_req, auto_req;
    logic [7:0] emer_target, crew_target, auto_target;
    logic [2:0] ack;
    logic [7:0] light_level;
    logic [1:0] active_src;
    logic       busy;
    logic       done;

    lighting_scene_controller #(.STEP_CYCLES(5), .STEP_SIZE(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .emer_req    (emer_req),
        .crew_req    (crew_req),
        .auto_req    (auto_req),
        .emer_target (emer_target),
        .crew_target (crew_target),
        .auto_target (auto_target),
        .ack         (ack),
        .light_level (light_level),
        .active_src  (active_src),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, er, cr, ar;
        logic [7:0] et, ct, at;
        logic [2:0] x_ack;
        logic [7:0] x_lvl;
        logic [1:0] x_src;
        logic       x_busy, x_done;
    } vec_t;

    vec_t tbl [64];
    int   n_tbl;
    int   n_vec;
    int   n_bad;
    int   dcount;

    function automatic vec_t mk(logic rst, logic e, logic er, logic cr, logic ar,
                                logic [7:0] et, logic [7:0] ct, logic [7:0] at,
                                logic [2:0] xa, logic [7:0] xl, logic [1:0] xs,
                                logic xb, logic xd);
        vec_t v;
        v.rst = rst; v.en = e; v.er = er; v.cr = cr; v.ar = ar;
        v.et = et; v.ct = ct; v.at = at;
        v.x_ack = xa; v.x_lvl = xl; v.x_src = xs; v.x_busy = xb; v.x_done = xd;
        return v;
    endfunction

    task automatic add(input vec_t v, input int n);
        for (int i = 0; i < n; i++) begin
            tbl[n_tbl] = v;
            n_tbl++;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        emer_req = 1'b0; crew_req = 1'b0; auto_req = 1'b0;
        emer_target = 8'd0; crew_target = 8'd0; auto_target = 8'd0;
    endtask

    task automatic do_reset();
        idle_in();
        en = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_all(input string nm, input logic [2:0] xa, input logic [7:0] xl,
                           input logic [1:0] xs, input logic xb, input logic xd);
        chk({nm, ".ack"},   ack,         xa);
        chk({nm, ".level"}, light_level, xl);
        chk({nm, ".src"},   active_src,  xs);
        chk({nm, ".busy"},  busy,        xb);
        chk({nm, ".done"},  done,        xd);
    endtask

    initial begin
        n_tbl = 0; n_vec = 0; n_bad = 0;
        reset = 1'b1; en = 1'b1;
        idle_in();

        // Reset, crew ramp to 40, freeze in IDLE, equal-target accepts at 40 and at 0.
        add(mk(1,1,0,0,0, 0,0,0,   3'b000, 0,  0, 0, 0), 1);
        add(mk(0,1,0,1,0, 0,40,0,  3'b010, 0,  2, 1, 0), 1);
        add(mk(0,1,0,0,0, 0,0,0,   3'b000, 0,  2, 1, 0), 4);
        add(mk(0,1,0,0,0, 0,0,0,   3'b000, 16, 2, 1, 0), 5);
        add(mk(0,1,0,0,0, 0,0,0,   3'b000, 32, 2, 1, 0), 5);
        add(mk(0,1,0,0,0, 0,0,0,   3'b000, 40, 0, 0, 1), 1);
        add(mk(0,1,0,0,0, 0,0,0,   3'b000, 40, 0, 0, 0), 1);
        add(mk(0,0,0,0,1, 0,0,10,  3'b000, 40, 0, 0, 0), 2);
        add(mk(0,1,0,0,1, 0,0,40,  3'b001, 40, 0, 0, 1), 1);
        add(mk(0,1,0,0,0, 0,0,0,   3'b000, 40, 0, 0, 0), 1);
        add(mk(1,1,0,1,0, 0,99,0,  3'b000, 0,  0, 0, 0), 1);
        add(mk(0,1,0,0,1, 0,0,0,   3'b001, 0,  0, 0, 1), 1);
        add(mk(0,1,0,0,0, 0,0,0,   3'b000, 0,  0, 0, 0), 2);

        for (int i = 0; i < n_tbl; i++) begin
            reset = tbl[i].rst; en = tbl[i].en;
            emer_req = tbl[i].er; crew_req = tbl[i].cr; auto_req = tbl[i].ar;
            emer_target = tbl[i].et; crew_target = tbl[i].ct; auto_target = tbl[i].at;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].x_ack, tbl[i].x_lvl, tbl[i].x_src,
                    tbl[i].x_busy, tbl[i].x_done);
        end
        reset = 1'b0;

        // crew and auto together: crew first, auto waits then ramps 50 -> 100.
        do_reset();
        auto_req = 1'b1; auto_target = 8'd100;
        crew_req = 1'b1; crew_target = 8'd50;
        tick();
        chk_all("prio.accept", 3'b010, 0, 2, 1, 0);
        crew_req = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk("prio.auto_held", ack, 0);
        end
        chk("prio.lvl48", light_level, 48);
        tick();
        chk_all("prio.crew_done", 3'b000, 50, 0, 0, 1);
        tick();
        chk_all("prio.auto_acc", 3'b001, 50, 1, 1, 0);
        auto_req = 1'b0;
        repeat (20) tick();
        chk_all("prio.auto_done", 3'b000, 100, 0, 0, 1);

        // Emergency preempts a crew ramp at level 48 and drives down to 0.
        do_reset();
        crew_req = 1'b1; crew_target = 8'd200;
        tick();
        chk_all("emer.crew_acc", 3'b010, 0, 2, 1, 0);
        crew_req = 1'b0;
        dcount = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            dcount += int'(done);
        end
        chk("emer.lvl48", light_level, 48);
        emer_req = 1'b1; emer_target = 8'd0;
        tick();
        dcount += int'(done);
        chk_all("emer.acc", 3'b100, 48, 3, 1, 0);
        tick();
        dcount += int'(done);
        chk("emer.reemer_ignored", ack, 0);
        emer_req = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            dcount += int'(done);
            if (i == 4)  chk("emer.lvl32", light_level, 32);
            if (i == 9)  chk("emer.lvl16", light_level, 16);
        end
        chk_all("emer.done", 3'b000, 0, 0, 0, 1);
        chk("emer.one_done", dcount, 1);

        // Freeze for 7 cycles with timer at 2; emer raised during freeze must not be taken.
        do_reset();
        crew_req = 1'b1; crew_target = 8'd40;
        tick();
        crew_req = 1'b0;
        repeat (5) tick();
        chk("frz.lvl16", light_level, 16);
        repeat (2) tick();
        en = 1'b0;
        emer_req = 1'b1; emer_target = 8'd0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all($sformatf("frz.hold%0d", i), 3'b000, 16, 2, 1, 0);
        end
        emer_req = 1'b0;
        en = 1'b1;
        repeat (2) tick();
        chk("frz.no_early_step", light_level, 16);
        tick();
        chk("frz.resume_step", light_level, 32);

        // Reset mid-ramp at level 80 beats a pending request.
        do_reset();
        crew_req = 1'b1; crew_target = 8'd200;
        tick();
        crew_req = 1'b0;
        repeat (25) tick();
        chk("rst.lvl80", light_level, 80);
        repeat (2) tick();
        reset = 1'b1;
        auto_req = 1'b1; auto_target = 8'd9;
        tick();
        chk_all("rst.mid", 3'b000, 0, 0, 0, 0);
        reset = 1'b0;
        auto_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
